// File: rtl/fei4_rx_link_ctrl_if.sv
// Handshake/status bundle between a FE-I4 receiver channel and its link
// supervisor. The master side is the receiver (or a bench standing in for it).
// The slave side is fei4_rx_link_ctrl.
interface fei4_rx_link_ctrl_if;
    logic       ENABLE;          // 1 = bring the link up and supervise it
    logic       REC_SYNC_READY;  // record sync lock reported by the receiver
    logic       WRITE;           // one strobe per valid decoded symbol
    logic       DECODER_ERR;     // code/disparity error, qualified by WRITE
    logic       LOST_ERR;        // CDC FIFO overflow pulse
    logic       RX_RESET;        // reset into the receiver datapath
    logic       LINK_UP;         // high only while LOCKED
    logic       LINK_FAIL;       // high only in FAIL
    logic [2:0] STATE;           // 0 DISABLED, 1 RST, 2 WAIT_SYNC, 3 LOCKED, 4 FAIL
    logic [7:0] RESYNC_CNT;      // resyncs issued from LOCKED, saturating
    logic [7:0] WIN_ERR_CNT;     // errors in the current window, saturating

    modport master (
        output ENABLE, REC_SYNC_READY, WRITE, DECODER_ERR, LOST_ERR,
        input  RX_RESET, LINK_UP, LINK_FAIL, STATE, RESYNC_CNT, WIN_ERR_CNT
    );

    modport slave (
        input  ENABLE, REC_SYNC_READY, WRITE, DECODER_ERR, LOST_ERR,
        output RX_RESET, LINK_UP, LINK_FAIL, STATE, RESYNC_CNT, WIN_ERR_CNT
    );
endinterface

// File: rtl/fei4_rx_link_ctrl.sv
// Link supervisor for one FE-I4 receiver channel (WCLK domain).
// It pulses the receiver reset and waits for record sync. It then watches the
// decoder error rate per window of symbols. An error burst or a loss of sync
// forces a resync. A link that cannot find sync after the allowed retries is
// declared failed.
// Optional feature: define FEI4_RX_LINK_CTRL_LOST_ERR_EN to count CDC FIFO
// overflow pulses (LOST_ERR) as errors while LOCKED.
module fei4_rx_link_ctrl #(
    parameter int WINDOW       = 1024,
    parameter int ERR_THRESH   = 16,
    parameter int SYNC_TIMEOUT = 4096,
    parameter int RST_PULSE    = 8,
    parameter int MAX_RETRY    = 7
) (
    input  logic                 WCLK,
    input  logic                 RESET,
    fei4_rx_link_ctrl_if.slave   bus
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int PULSE_W = $clog2(RST_PULSE + 1);
    localparam int TOUT_W  = $clog2(SYNC_TIMEOUT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    // Room for a count that can overshoot the threshold by two in one cycle.
    localparam int ERR_W   = $clog2(ERR_THRESH + 3);

    typedef enum logic [2:0] {
        S_DISABLED  = 3'd0,
        S_RST       = 3'd1,
        S_WAIT_SYNC = 3'd2,
        S_LOCKED    = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t             state_q;
    logic               rx_reset_q;
    logic               link_up_q;
    logic               link_fail_q;
    logic [7:0]         resync_cnt_q;
    logic [7:0]         win_err_cnt_q;
    logic [RETRY_W-1:0] retry_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [TOUT_W-1:0]  timeout_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [ERR_W-1:0]   err_cnt;

    logic [1:0]         err_inc;
    logic [ERR_W-1:0]   err_next;
    logic               thresh_hit;
    logic [7:0]         err_next_sat;

    // Errors contributed by this cycle and the resulting window count.
    always_comb begin
        err_inc = {1'b0, bus.WRITE & bus.DECODER_ERR};
`ifdef FEI4_RX_LINK_CTRL_LOST_ERR_EN
        err_inc = err_inc + {1'b0, bus.LOST_ERR};
`endif
        err_next     = err_cnt + ERR_W'(err_inc);
        thresh_hit   = (err_inc != 2'd0) && (32'(err_next) >= ERR_THRESH);
        err_next_sat = (32'(err_next) > 255) ? 8'hFF : 8'(err_next);
    end

    // Supervisor sequencer. Every output is a register updated here.
    // NOTE: state registers use non-blocking assignments so that every branch reads pre-edge values.
    always_ff @(posedge WCLK) begin
        if (RESET) begin
            state_q       <= S_DISABLED;
            rx_reset_q    <= 1'b1;
            link_up_q     <= 1'b0;
            link_fail_q   <= 1'b0;
            resync_cnt_q  <= 8'd0;
            win_err_cnt_q <= 8'd0;
            retry_cnt     <= '0;
            pulse_cnt     <= '0;
            timeout_cnt   <= '0;
            win_cnt       <= '0;
            err_cnt       <= '0;
        end else if (!bus.ENABLE) begin
            state_q     <= S_DISABLED;
            rx_reset_q  <= 1'b1;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
        end else begin
            case (state_q)
                S_DISABLED: begin
                    state_q   <= S_RST;
                    rx_reset_q <= 1'b1;
                    retry_cnt <= '0;
                    pulse_cnt <= '0;
                end
                S_RST: begin
                    if (32'(pulse_cnt) == RST_PULSE - 1) begin
                        state_q     <= S_WAIT_SYNC;
                        rx_reset_q  <= 1'b0;
                        timeout_cnt <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                S_WAIT_SYNC: begin
                    if (bus.REC_SYNC_READY) begin
                        // Lock wins even on the timeout cycle.
                        state_q       <= S_LOCKED;
                        link_up_q     <= 1'b1;
                        win_cnt       <= '0;
                        err_cnt       <= '0;
                        win_err_cnt_q <= 8'd0;
                        retry_cnt     <= '0;
                    end else if (32'(timeout_cnt) == SYNC_TIMEOUT - 1) begin
                        rx_reset_q <= 1'b1;
                        if (32'(retry_cnt) == MAX_RETRY) begin
                            state_q     <= S_FAIL;
                            link_fail_q <= 1'b1;
                        end else begin
                            state_q   <= S_RST;
                            retry_cnt <= retry_cnt + 1'b1;
                            pulse_cnt <= '0;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (thresh_hit || !bus.REC_SYNC_READY) begin
                        // Error burst or sync loss: one resync, counted once.
                        state_q    <= S_RST;
                        rx_reset_q <= 1'b1;
                        link_up_q  <= 1'b0;
                        pulse_cnt  <= '0;
                        if (resync_cnt_q != 8'hFF)
                            resync_cnt_q <= resync_cnt_q + 8'd1;
                    end else if (bus.WRITE && (32'(win_cnt) == WINDOW - 1)) begin
                        win_cnt       <= '0;
                        err_cnt       <= '0;
                        win_err_cnt_q <= 8'd0;
                    end else begin
                        if (bus.WRITE)
                            win_cnt <= win_cnt + 1'b1;
                        err_cnt       <= err_next;
                        win_err_cnt_q <= err_next_sat;
                    end
                end
                S_FAIL: begin
                    rx_reset_q  <= 1'b1;
                    link_fail_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_DISABLED;
                    rx_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.RX_RESET    = rx_reset_q;
    assign bus.LINK_UP     = link_up_q;
    assign bus.LINK_FAIL   = link_fail_q;
    assign bus.STATE       = state_q;
    assign bus.RESYNC_CNT  = resync_cnt_q;
    assign bus.WIN_ERR_CNT = win_err_cnt_q;

endmodule

// File: tb/tb_fei4_rx_link_ctrl.sv
// Directed bench for fei4_rx_link_ctrl with a small configuration.
// The configuration is WINDOW=16, ERR_THRESH=4, SYNC_TIMEOUT=32, RST_PULSE=4 and MAX_RETRY=2.
// Inputs change 1 ns after the rising edge, and outputs are sampled at that same point.
module tb_fei4_rx_link_ctrl;

    logic WCLK = 1'b0;
    logic RESET;
    int   errors = 0;
    int   checks = 0;

    fei4_rx_link_ctrl_if bus();

    fei4_rx_link_ctrl #(
        .WINDOW(16), .ERR_THRESH(4), .SYNC_TIMEOUT(32), .RST_PULSE(4), .MAX_RETRY(2)
    ) dut (
        .WCLK  (WCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 WCLK = ~WCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge WCLK);
        #1;
    endtask

    task automatic strobe(input logic err);
        bus.WRITE       = 1'b1;
        bus.DECODER_ERR = err;
        tick();
        bus.WRITE       = 1'b0;
        bus.DECODER_ERR = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (bus.STATE != s && n < budget) begin
            tick();
            n++;
        end
        check(tag, bus.STATE, s);
    endtask

    initial begin
        int cyc, rst_entries, wait_len, wait_min, wait_max;
        logic [2:0] prev;
        int base;

        RESET              = 1'b1;
        bus.ENABLE         = 1'b0;
        bus.REC_SYNC_READY = 1'b0;
        bus.WRITE          = 1'b0;
        bus.DECODER_ERR    = 1'b0;
        bus.LOST_ERR       = 1'b0;
        tick();
        tick();
        check("rst_state", bus.STATE, 0);
        check("rst_rx_reset", bus.RX_RESET, 1);
        check("rst_link_up", bus.LINK_UP, 0);
        check("rst_link_fail", bus.LINK_FAIL, 0);
        check("rst_resync", bus.RESYNC_CNT, 0);
        check("rst_win_err", bus.WIN_ERR_CNT, 0);
        RESET = 1'b0;
        tick();
        check("disabled_hold", bus.STATE, 0);

        // 1: bring-up, 4-cycle reset pulse, sync after 10 cycles in WAIT_SYNC
        bus.ENABLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_rst_state", bus.STATE, 1);
            check("t1_rx_reset", bus.RX_RESET, 1);
        end
        tick();
        check("t1_wait_state", bus.STATE, 2);
        check("t1_rx_reset_low", bus.RX_RESET, 0);
        repeat (9) tick();
        check("t1_still_wait", bus.STATE, 2);
        check("t1_not_up", bus.LINK_UP, 0);
        bus.REC_SYNC_READY = 1'b1;
        tick();
        check("t1_locked", bus.STATE, 3);
        check("t1_link_up", bus.LINK_UP, 1);

        // 3: 3 errors per window for 10 windows, then 4th error on the 16th strobe
        for (int w = 0; w < 10; w++) begin
            for (int s = 0; s < 16; s++) begin
                strobe(s == 0 || s == 5 || s == 10);
                if (w == 0 && s == 10) check("t3_mid_win_err", bus.WIN_ERR_CNT, 3);
            end
            check("t3_win_clear", bus.WIN_ERR_CNT, 0);
            check("t3_still_locked", bus.STATE, 3);
        end
        check("t3_no_resync", bus.RESYNC_CNT, 0);
        for (int s = 0; s < 15; s++) strobe(s == 0 || s == 5 || s == 10);
        check("t3_pre_err", bus.WIN_ERR_CNT, 3);
        strobe(1'b1);
        check("t3_resync_state", bus.STATE, 1);
        check("t3_resync_cnt", bus.RESYNC_CNT, 1);
        wait_state(3'd3, 20, "t3_relock");
        check("t3_relock_err_clr", bus.WIN_ERR_CNT, 0);

        // 2: four errored strobes within one window
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        check("t2_err3", bus.WIN_ERR_CNT, 3);
        check("t2_locked", bus.STATE, 3);
        strobe(1'b1);
        check("t2_rst_state", bus.STATE, 1);
        check("t2_rx_reset", bus.RX_RESET, 1);
        check("t2_link_up_low", bus.LINK_UP, 0);
        check("t2_resync_cnt", bus.RESYNC_CNT, 2);
        wait_state(3'd3, 20, "t2_relock");

        // 5: ENABLE low while LOCKED keeps RESYNC_CNT; RESET clears it
        bus.ENABLE = 1'b0;
        tick();
        check("t5_disabled", bus.STATE, 0);
        check("t5_link_up", bus.LINK_UP, 0);
        check("t5_rx_reset", bus.RX_RESET, 1);
        check("t5_resync_kept", bus.RESYNC_CNT, 2);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("t5_resync_clr", bus.RESYNC_CNT, 0);

        // 4: sync never comes -> 3 reset pulses, 32-cycle waits, then FAIL
        bus.REC_SYNC_READY = 1'b0;
        bus.ENABLE = 1'b1;
        cyc = 0; rst_entries = 0; wait_len = 0; wait_min = 9999; wait_max = 0;
        prev = bus.STATE;
        while (bus.STATE != 3'd4 && cyc < 300) begin
            tick();
            cyc++;
            if (bus.STATE == 3'd1 && prev != 3'd1) rst_entries++;
            if (bus.STATE == 3'd2) begin
                wait_len++;
            end else if (prev == 3'd2) begin
                if (wait_len < wait_min) wait_min = wait_len;
                if (wait_len > wait_max) wait_max = wait_len;
                wait_len = 0;
            end
            prev = bus.STATE;
        end
        check("t4_fail_state", bus.STATE, 4);
        check("t4_cycles", cyc, 109);
        check("t4_rst_pulses", rst_entries, 3);
        check("t4_wait_min", wait_min, 32);
        check("t4_wait_max", wait_max, 32);
        check("t4_link_fail", bus.LINK_FAIL, 1);
        check("t4_rx_reset", bus.RX_RESET, 1);
        repeat (5) tick();
        check("t4_fail_sticky", bus.STATE, 4);
        bus.ENABLE = 1'b0;
        tick();
        check("t4_disabled", bus.STATE, 0);
        check("t4_fail_clr", bus.LINK_FAIL, 0);

        // Sync arriving on the timeout cycle locks instead of retrying
        bus.ENABLE = 1'b1;
        repeat (5) tick();
        check("tb_wait_entry", bus.STATE, 2);
        repeat (31) tick();
        check("tb_wait_last", bus.STATE, 2);
        bus.REC_SYNC_READY = 1'b1;
        tick();
        check("tb_lock_on_timeout", bus.STATE, 3);

        // 6: LOST_ERR pulses
        for (int i = 0; i < 4; i++) begin
            bus.LOST_ERR = 1'b1;
            tick();
            bus.LOST_ERR = 1'b0;
            if (i < 3) tick();
        end
`ifdef FEI4_RX_LINK_CTRL_LOST_ERR_EN
        check("t6_lost_resync", bus.STATE, 1);
        check("t6_lost_cnt", bus.RESYNC_CNT, 1);
        base = 1;
        wait_state(3'd3, 20, "t6_relock");
`else
        check("t6_lost_ignored", bus.STATE, 3);
        check("t6_lost_cnt", bus.RESYNC_CNT, 0);
        check("t6_lost_win_err", bus.WIN_ERR_CNT, 0);
        base = 0;
`endif

        // Sync loss while LOCKED
        bus.REC_SYNC_READY = 1'b0;
        tick();
        check("t7_sync_loss_state", bus.STATE, 1);
        check("t7_sync_loss_cnt", bus.RESYNC_CNT, base + 1);
        check("t7_link_up", bus.LINK_UP, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
